// File: rtl/warning_annunciator.sv
`default_nettype none
// ============================================================================
// Module      : warning_annunciator
// Description : Turns the warning flags from the safety logic into timed
//               driver feedback: chime pattern, warning lamp, fault code and
//               a qualified start enable. Sources are ranked by severity
//               (PRI1: battery/airbag/temp, PRI2: seat/door/chime_req) and a
//               driver acknowledge silences PRI2 warnings.
// Ports       : clk          - system clock
//               rst_n        - asynchronous active-low reset
//               bat_warn     - battery fault (PRI1)
//               airbag_warn  - airbag fault (PRI1)
//               temp_warn    - temperature fault (PRI1)
//               seat_warn    - seatbelt warning (PRI2)
//               door_warn    - door warning (PRI2)
//               chime_req    - door-open-with-key chime request (PRI2)
//               start_permit - start permission from safety logic
//               ack_btn      - driver acknowledge button (level)
//               chime        - chime drive
//               lamp         - warning lamp drive
//               start_en     - qualified start enable
//               fault_code   - 0 none,1 bat,2 airbag,3 temp,4 seat,5 door
//               state_o      - 0 IDLE, 1 PRI1, 2 PRI2, 3 ACKED
// Options     : ANNUNC_ESCALATE_EN - an unacknowledged PRI2 warning escalates
//               to a PRI1-style alert after ESC_TICKS pattern ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module warning_annunciator #(
  parameter int TICK_DIV  = 100000,
  parameter int BEEP_ON   = 5,
  parameter int BEEP_OFF  = 5,
  parameter int ESC_TICKS = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bat_warn,
  input  logic       airbag_warn,
  input  logic       temp_warn,
  input  logic       seat_warn,
  input  logic       door_warn,
  input  logic       chime_req,
  input  logic       start_permit,
  input  logic       ack_btn,
  output logic       chime,
  output logic       lamp,
  output logic       start_en,
  output logic [2:0] fault_code,
  output logic [1:0] state_o
);

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int PERIOD = BEEP_ON + BEEP_OFF;
  localparam int PAT_W  = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [PAT_W-1:0]  PAT_LAST  = PAT_W'(PERIOD - 1);
  localparam logic [PAT_W-1:0]  PAT_ON    = PAT_W'(BEEP_ON);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRI1  = 3'd1;
  localparam logic [2:0] ST_PRI2  = 3'd2;
  localparam logic [2:0] ST_ACKED = 3'd3;
`ifdef ANNUNC_ESCALATE_EN
  localparam logic [2:0] ST_ESC   = 3'd4;
`endif

  // Elaboration-time sanity checks on the configuration.
  if (TICK_DIV < 2) begin : g_chk_tick_div
    $error("warning_annunciator: TICK_DIV must be >= 2");
  end
  if (BEEP_ON < 1 || BEEP_OFF < 1) begin : g_chk_beep
    $error("warning_annunciator: BEEP_ON and BEEP_OFF must be >= 1");
  end
  if (ESC_TICKS < 1) begin : g_chk_esc
    $error("warning_annunciator: ESC_TICKS must be >= 1");
  end

  // --------------------------------------------------------------------------
  // Input synchroniser (2 flops on every asynchronous input)
  // --------------------------------------------------------------------------
  logic [7:0] w_async_in;
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;

  assign w_async_in = {ack_btn, start_permit, chime_req, door_warn,
                       seat_warn, temp_warn, airbag_warn, bat_warn};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_async_in;
      r_sync2 <= r_sync1;
    end
  end

  logic       w_bat, w_airbag, w_temp, w_seat, w_door_any;
  logic       w_pri1, w_pri2, w_permit, w_ack;
  logic [2:0] w_pri2_vec;

  assign w_bat      = r_sync2[0];
  assign w_airbag   = r_sync2[1];
  assign w_temp     = r_sync2[2];
  assign w_seat     = r_sync2[3];
  assign w_door_any = r_sync2[4] | r_sync2[5];  // chime_req reports as door
  assign w_pri2_vec = r_sync2[5:3];
  assign w_permit   = r_sync2[6];
  assign w_ack      = r_sync2[7];
  assign w_pri1     = |r_sync2[2:0];
  assign w_pri2     = |w_pri2_vec;

  // Edge detector: the previous sample tracks the button in every state, so a
  // button held across a state change never produces a second acknowledge.
  logic r_ack_d;
  logic w_ack_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ack_d <= 1'b0;
    else        r_ack_d <= w_ack;
  end

  assign w_ack_rise = w_ack & ~r_ack_d;

  // --------------------------------------------------------------------------
  // Free-running tick generator
  // --------------------------------------------------------------------------
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TICK_W'(1);
  end

  // --------------------------------------------------------------------------
  // Escalation counter (only in the escalating build)
  // --------------------------------------------------------------------------
`ifdef ANNUNC_ESCALATE_EN
  localparam int ESC_W = $clog2(ESC_TICKS + 1);
  localparam logic [ESC_W-1:0] ESC_LAST = ESC_W'(ESC_TICKS - 1);

  logic [2:0]       r_state;
  logic [ESC_W-1:0] r_esc_cnt;
  logic             w_esc_hit;

  // Fires on the tick that completes ESC_TICKS ticks spent in PRI2.
  assign w_esc_hit = (r_state == ST_PRI2) && w_tick && (r_esc_cnt == ESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_esc_cnt <= '0;
    else if (r_state != ST_PRI2)   r_esc_cnt <= '0;
    else if (w_tick && r_esc_cnt != ESC_LAST)
                                   r_esc_cnt <= r_esc_cnt + ESC_W'(1);
  end
`else
  logic [2:0] r_state;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  logic [2:0] w_state_next;
  logic [2:0] r_mask;
  logic [2:0] w_mask_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= w_mask_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. PRI1 is checked first everywhere so it wins over
  // a same-cycle acknowledge or PRI2 onset.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pri1)      w_state_next = ST_PRI1;
        else if (w_pri2) w_state_next = ST_PRI2;
      end
      ST_PRI1: begin
        if (!w_pri1) w_state_next = w_pri2 ? ST_PRI2 : ST_IDLE;
      end
      ST_PRI2: begin
        if (w_pri1)          w_state_next = ST_PRI1;
        else if (!w_pri2)    w_state_next = ST_IDLE;
        else if (w_ack_rise) w_state_next = ST_ACKED;
`ifdef ANNUNC_ESCALATE_EN
        else if (w_esc_hit)  w_state_next = ST_ESC;
`endif
      end
      ST_ACKED: begin
        if (w_pri1)                          w_state_next = ST_PRI1;
        else if (!w_pri2)                    w_state_next = ST_IDLE;
        else if (|(w_pri2_vec & ~r_mask))    w_state_next = ST_PRI2;
      end
`ifdef ANNUNC_ESCALATE_EN
      ST_ESC: begin
        if (w_pri1)       w_state_next = ST_PRI1;
        else if (!w_pri2) w_state_next = ST_IDLE;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The mask only has meaning while ACKED: it is captured on the PRI2->ACKED
  // acknowledge and cleared on any exit.
  always_comb begin
    w_mask_next = '0;
    if (w_state_next == ST_ACKED)
      w_mask_next = (r_state == ST_PRI2) ? w_pri2_vec : r_mask;
  end

  // --------------------------------------------------------------------------
  // Pattern counter: restarts in the ON phase on every state change.
  // --------------------------------------------------------------------------
  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] w_pat_next;
  logic             w_phase_on;

  always_comb begin
    w_pat_next = r_pat;
    if (w_state_next != r_state) w_pat_next = '0;
    else if (w_tick)             w_pat_next = (r_pat == PAT_LAST) ? '0 : r_pat + PAT_W'(1);
  end

  assign w_phase_on = (w_pat_next < PAT_ON);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pat <= '0;
    else        r_pat <= w_pat_next;
  end

  // --------------------------------------------------------------------------
  // FSM: output logic. Outputs are decoded from the next state so that the
  // registered outputs change on the same edge as the state register.
  // --------------------------------------------------------------------------
  logic       w_chime_next;
  logic       w_lamp_next;
  logic       w_start_next;
  logic [1:0] w_state_o_next;
  logic [2:0] w_code_next;

  always_comb begin
    w_chime_next   = 1'b0;
    w_lamp_next    = 1'b0;
    w_state_o_next = 2'd0;
    case (w_state_next)
      ST_PRI1: begin
        w_chime_next   = w_phase_on;
        w_lamp_next    = 1'b1;
        w_state_o_next = 2'd1;
      end
      ST_PRI2: begin
        w_chime_next   = w_phase_on;
        w_lamp_next    = w_phase_on;
        w_state_o_next = 2'd2;
      end
      ST_ACKED: begin
        w_lamp_next    = 1'b1;
        w_state_o_next = 2'd3;
      end
`ifdef ANNUNC_ESCALATE_EN
      ST_ESC: begin
        w_chime_next   = w_phase_on;
        w_lamp_next    = 1'b1;
        w_state_o_next = 2'd1;
      end
`endif
      default: ;
    endcase

    w_start_next = w_permit && (w_state_o_next != 2'd1);

    if (w_bat)           w_code_next = 3'd1;
    else if (w_airbag)   w_code_next = 3'd2;
    else if (w_temp)     w_code_next = 3'd3;
    else if (w_seat)     w_code_next = 3'd4;
    else if (w_door_any) w_code_next = 3'd5;
    else                 w_code_next = 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chime      <= 1'b0;
      lamp       <= 1'b0;
      start_en   <= 1'b0;
      fault_code <= 3'd0;
      state_o    <= 2'd0;
    end else begin
      chime      <= w_chime_next;
      lamp       <= w_lamp_next;
      start_en   <= w_start_next;
      fault_code <= w_code_next;
      state_o    <= w_state_o_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_warning_annunciator.sv
`default_nettype none
// ============================================================================
// Module      : tb_warning_annunciator
// Description : Directed self-checking bench for warning_annunciator with
//               TICK_DIV=4, BEEP_ON=2, BEEP_OFF=2, ESC_TICKS=6. Honours
//               ANNUNC_ESCALATE_EN for the escalation step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_warning_annunciator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bat_warn, airbag_warn, temp_warn;
  logic       seat_warn, door_warn, chime_req;
  logic       start_permit, ack_btn;
  logic       chime, lamp, start_en;
  logic [2:0] fault_code;
  logic [1:0] state_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  warning_annunciator #(
    .TICK_DIV (4),
    .BEEP_ON  (2),
    .BEEP_OFF (2),
    .ESC_TICKS(6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bat_warn    (bat_warn),
    .airbag_warn (airbag_warn),
    .temp_warn   (temp_warn),
    .seat_warn   (seat_warn),
    .door_warn   (door_warn),
    .chime_req   (chime_req),
    .start_permit(start_permit),
    .ack_btn     (ack_btn),
    .chime       (chime),
    .lamp        (lamp),
    .start_en    (start_en),
    .fault_code  (fault_code),
    .state_o     (state_o)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (observed=timeout expected=finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    rst_n = 1'b0;
    bat_warn = 0; airbag_warn = 0; temp_warn = 0;
    seat_warn = 0; door_warn = 0; chime_req = 0;
    start_permit = 1'b1; ack_btn = 1'b0;

    // ---- 1. reset and idle ----
    step(2);
    check("rst_chime", chime, 0);
    check("rst_lamp", lamp, 0);
    check("rst_start_en", start_en, 0);
    check("rst_code", fault_code, 0);
    check("rst_state", state_o, 0);
    rst_n = 1'b1;
    step(3);
    check("idle_start_en", start_en, 1);
    check("idle_chime", chime, 0);
    check("idle_lamp", lamp, 0);
    check("idle_code", fault_code, 0);
    check("idle_state", state_o, 0);

    // ---- 2. battery fault: PRI1 ----
    bat_warn = 1;
    step(2);
    check("pri1_latency_state", state_o, 0);
    step(1);
    check("pri1_state", state_o, 1);
    check("pri1_code", fault_code, 1);
    check("pri1_chime_entry", chime, 1);
    check("pri1_lamp", lamp, 1);
    check("pri1_start_en", start_en, 0);
    // Find the end of the first ON phase, then measure a full low and high.
    n = 0;
    while (chime === 1'b1 && n < 20) begin n++; step(1); end
    n = 0;
    while (chime === 1'b0 && n < 20) begin n++; step(1); end
    check("pri1_chime_low_len", n, 8);
    n = 0;
    while (chime === 1'b1 && n < 20) begin
      if (lamp !== 1'b1) check("pri1_lamp_steady", lamp, 1);
      n++;
      step(1);
    end
    check("pri1_chime_high_len", n, 8);
    ack_btn = 1; step(1); ack_btn = 0;
    step(4);
    check("pri1_ack_ignored", state_o, 1);

    // ---- 3. seatbelt: PRI2, ack, new door source ----
    bat_warn = 0; seat_warn = 1;
    step(3);
    check("pri2_state", state_o, 2);
    check("pri2_code", fault_code, 4);
    check("pri2_chime_entry", chime, 1);
    check("pri2_start_en", start_en, 1);
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("pri2_lamp_blink", lamp, chime);
    end
    ack_btn = 1; step(1); ack_btn = 0;
    step(2);
    check("acked_state", state_o, 3);
    check("acked_chime", chime, 0);
    check("acked_lamp", lamp, 1);
    door_warn = 1;
    step(3);
    check("new_src_state", state_o, 2);
    check("new_src_code", fault_code, 4);

    // ---- 4. PRI1 wins over a same-cycle ack edge ----
    ack_btn = 1; step(1); ack_btn = 0;
    step(2);
    check("reack_state", state_o, 3);
    step(2);
    temp_warn = 1; ack_btn = 1;
    step(3);
    check("pri1_vs_ack_state", state_o, 1);
    check("pri1_vs_ack_code", fault_code, 3);
    ack_btn = 0; temp_warn = 0;
    step(3);
    check("ack_dropped_state", state_o, 2);
    check("ack_dropped_code", fault_code, 4);

    // ---- 5. async reset mid PRI1 chime-high ----
    seat_warn = 0; door_warn = 0; bat_warn = 1;
    step(3);
    check("pre_rst_state", state_o, 1);
    check("pre_rst_chime", chime, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_chime", chime, 0);
    check("async_rst_lamp", lamp, 0);
    check("async_rst_start_en", start_en, 0);
    check("async_rst_code", fault_code, 0);
    check("async_rst_state", state_o, 0);
    step(1);
    rst_n = 1'b1;
    step(2);
    check("post_rst_idle", state_o, 0);
    step(1);
    check("post_rst_state", state_o, 1);
    check("post_rst_chime_on", chime, 1);

    // ---- 6. unacked PRI2 door warning ----
    bat_warn = 0; door_warn = 1;
    step(3);
    check("door_state", state_o, 2);
    check("door_code", fault_code, 5);
    step(18);
    check("door_pre_esc_state", state_o, 2);
    step(6);
`ifdef ANNUNC_ESCALATE_EN
    check("esc_state", state_o, 1);
    check("esc_start_en", start_en, 0);
    check("esc_lamp", lamp, 1);
`else
    check("no_esc_state", state_o, 2);
    check("no_esc_start_en", start_en, 1);
`endif
    door_warn = 0;
    step(3);
    check("door_clear_state", state_o, 0);

    // ---- 7. simultaneous PRI1/PRI2 onset, held ack, chime_req ----
    bat_warn = 1; seat_warn = 1;
    step(3);
    check("onset_state", state_o, 1);
    check("onset_code", fault_code, 1);
    bat_warn = 0; seat_warn = 0;
    step(3);
    check("onset_clear_state", state_o, 0);
    ack_btn = 1;
    step(4);
    chime_req = 1;
    step(3);
    check("held_ack_state", state_o, 2);
    check("chime_req_code", fault_code, 5);
    step(3);
    check("held_ack_no_reack", state_o, 2);
    ack_btn = 0; step(3);
    ack_btn = 1; step(3);
    check("fresh_ack_state", state_o, 3);
    ack_btn = 0; chime_req = 0;
    step(3);
    check("final_idle", state_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
